// File: rtl/pixel_filter_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pixel_filter_ctrl
// Brief    : Shadowed filter configuration, applied only at frame boundaries.
// Revision : 1.0
// ============================================================================
module pixel_filter_ctrl #(
   parameter  int MIN_BPM         = 40,
   parameter  int MAX_BPM         = 200,
   parameter  int FRAMES_PER_MODE = 30,
   parameter  int FCNT_W          = 16,
   localparam int BPM_W           = $clog2(MAX_BPM + 1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic              in_ready,
   input  logic              in_sop,
   input  logic              in_eop,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic              cfg_enable,
   input  logic              cfg_mode,
   input  logic [BPM_W-1:0]  cfg_bpm,
   input  logic              auto_cycle,
   output logic              filter_enable,
   output logic              filter_mode,
   output logic [BPM_W-1:0]  BPM_estimate,
   output logic [FCNT_W-1:0] frame_count,
   output logic              cfg_pending,
   output logic              sop_err
);

   localparam int               MFC_W      = (FRAMES_PER_MODE > 1) ? $clog2(FRAMES_PER_MODE) : 1;
   localparam logic [BPM_W-1:0] C_MIN_BPM  = BPM_W'(MIN_BPM);
   localparam logic [BPM_W-1:0] C_MAX_BPM  = BPM_W'(MAX_BPM);
   localparam logic [MFC_W-1:0] C_MFC_LAST = MFC_W'(FRAMES_PER_MODE - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_FRAME  = 2'd1,
      ST_UPDATE = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic               w_beat;
   logic               w_cfg_acc;
   logic               w_set_err;
   logic               w_count_nxt;
   logic               r_counted;
   logic [BPM_W-1:0]   w_bpm_clamped;
   logic               r_sh_en;
   logic               r_sh_mode;
   logic [BPM_W-1:0]   r_sh_bpm;
   logic               r_en;
   logic               r_mode;
   logic [BPM_W-1:0]   r_bpm;
   logic [FCNT_W-1:0]  r_fcnt;
   logic [MFC_W-1:0]   r_mfc;
   logic               r_pending;
   logic               r_err;

   assign w_beat    = in_valid & in_ready;
   assign cfg_ready = (r_state != ST_UPDATE);
   assign w_cfg_acc = cfg_valid & cfg_ready;

   always_comb begin
      w_bpm_clamped = cfg_bpm;
      if (cfg_bpm < C_MIN_BPM) begin
         w_bpm_clamped = C_MIN_BPM;
      end else if (cfg_bpm > C_MAX_BPM) begin
         w_bpm_clamped = C_MAX_BPM;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_set_err   = 1'b0;
      w_count_nxt = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_beat) begin
               if (in_sop && in_eop) begin
                  w_state_nxt = ST_UPDATE;
                  w_count_nxt = 1'b1;
               end else if (in_sop) begin
                  w_state_nxt = ST_FRAME;
               end else begin
                  w_set_err = 1'b1;
               end
            end else if (r_pending) begin
               w_state_nxt = ST_UPDATE;
            end
         end
         ST_FRAME: begin
            if (w_beat && in_eop) begin
               w_state_nxt = ST_UPDATE;
               w_count_nxt = 1'b1;
            end else if (w_beat && in_sop) begin
               w_set_err = 1'b1;
            end
         end
         ST_UPDATE: w_state_nxt = ST_IDLE;
         default:   w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= ST_IDLE;
         r_counted <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_counted <= w_count_nxt;
      end
   end

   // Active registers move only while in UPDATE, so the filter never sees a mid-frame change.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sh_en   <= 1'b0;
         r_sh_mode <= 1'b0;
         r_sh_bpm  <= C_MIN_BPM;
         r_en      <= 1'b0;
         r_mode    <= 1'b0;
         r_bpm     <= C_MIN_BPM;
         r_fcnt    <= '0;
         r_mfc     <= '0;
         r_pending <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         if (w_set_err) begin
            r_err <= 1'b1;
         end
         if (w_cfg_acc) begin
            r_sh_en   <= cfg_enable;
            r_sh_mode <= cfg_mode;
            r_sh_bpm  <= w_bpm_clamped;
            r_pending <= 1'b1;
         end
         if (!auto_cycle) begin
            r_mfc <= '0;
         end
         if (r_state == ST_UPDATE) begin
            r_en      <= r_sh_en;
            r_bpm     <= r_sh_bpm;
            r_pending <= 1'b0;
            if (r_counted) begin
               r_fcnt <= r_fcnt + 1'b1;
            end
            if (!auto_cycle) begin
               r_mode <= r_sh_mode;
            end else if (r_counted) begin
               if (r_mfc == C_MFC_LAST) begin
                  r_mfc  <= '0;
                  r_mode <= ~r_mode;
               end else begin
                  r_mfc <= r_mfc + 1'b1;
               end
            end
         end
      end
   end

   assign filter_enable = r_en;
   assign filter_mode   = r_mode;
   assign BPM_estimate  = r_bpm;
   assign frame_count   = r_fcnt;
   assign cfg_pending   = r_pending;
   assign sop_err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_pixel_filter_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pixel_filter_ctrl
// Brief    : Directed bench for pixel_filter_ctrl with a queue of expected applies.
// Revision : 1.0
// ============================================================================
module tb_pixel_filter_ctrl;

   localparam int FPM    = 3;
   localparam int FCNT_W = 16;
   localparam int BPM_W  = 8;

   logic              clk = 1'b0;
   logic              reset;
   logic              in_valid, in_ready, in_sop, in_eop;
   logic              cfg_valid, cfg_ready, cfg_enable, cfg_mode, auto_cycle;
   logic [BPM_W-1:0]  cfg_bpm, BPM_estimate;
   logic              filter_enable, filter_mode, cfg_pending, sop_err;
   logic [FCNT_W-1:0] frame_count;

   int n_assert = 0;
   int n_fail   = 0;

   typedef struct packed {
      logic        en;
      logic        mode;
      logic [7:0]  bpm;
      logic [15:0] fcnt;
   } exp_t;

   exp_t        exp_q[$];
   logic        s_en, s_mode, m_en, m_mode;
   logic [7:0]  s_bpm, m_bpm;
   logic [15:0] m_fcnt;
   int          m_mfc;

   pixel_filter_ctrl #(
      .MIN_BPM         (40),
      .MAX_BPM         (200),
      .FRAMES_PER_MODE (FPM),
      .FCNT_W          (FCNT_W)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_sop        (in_sop),
      .in_eop        (in_eop),
      .cfg_valid     (cfg_valid),
      .cfg_ready     (cfg_ready),
      .cfg_enable    (cfg_enable),
      .cfg_mode      (cfg_mode),
      .cfg_bpm       (cfg_bpm),
      .auto_cycle    (auto_cycle),
      .filter_enable (filter_enable),
      .filter_mode   (filter_mode),
      .BPM_estimate  (BPM_estimate),
      .frame_count   (frame_count),
      .cfg_pending   (cfg_pending),
      .sop_err       (sop_err)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_assert++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp_v);
      end
   endtask

   task automatic model_reset();
      m_en = 1'b0; m_mode = 1'b0; m_bpm = 8'd40; m_fcnt = 16'd0; m_mfc = 0;
      s_en = 1'b0; s_mode = 1'b0; s_bpm = 8'd40;
      exp_q.delete();
   endtask

   task automatic chk_active(input string tag);
      chk({tag, "_en"},   filter_enable, m_en);
      chk({tag, "_mode"}, filter_mode,   m_mode);
      chk({tag, "_bpm"},  BPM_estimate,  m_bpm);
      chk({tag, "_fcnt"}, frame_count,   m_fcnt);
   endtask

   // Expected post-UPDATE outputs, pushed as soon as the triggering stimulus is driven.
   task automatic predict(input bit counted);
      exp_t e;
      e.en   = s_en;
      e.bpm  = s_bpm;
      e.mode = m_mode;
      e.fcnt = counted ? m_fcnt + 16'd1 : m_fcnt;
      if (!auto_cycle) begin
         e.mode = s_mode;
         m_mfc  = 0;
      end else if (counted) begin
         if (m_mfc == FPM - 1) begin
            m_mfc  = 0;
            e.mode = ~m_mode;
         end else begin
            m_mfc++;
         end
      end
      exp_q.push_back(e);
   endtask

   task automatic wait_apply(input int lat, input string tag);
      int   cnt = 0;
      exp_t e;
      while (cfg_ready === 1'b1 && cnt < 40) begin
         @(negedge clk);
         cnt++;
      end
      chk({tag, "_lat"}, cnt, lat);
      if (cfg_ready === 1'b0) begin
         chk_active({tag, "_hold"});
         @(negedge clk);
      end
      e = exp_q.pop_front();
      chk({tag, "_en"},   filter_enable, e.en);
      chk({tag, "_mode"}, filter_mode,   e.mode);
      chk({tag, "_bpm"},  BPM_estimate,  e.bpm);
      chk({tag, "_fcnt"}, frame_count,   e.fcnt);
      chk({tag, "_pend"}, cfg_pending,   1'b0);
      chk({tag, "_rdy"},  cfg_ready,     1'b1);
      m_en = e.en; m_mode = e.mode; m_bpm = e.bpm; m_fcnt = e.fcnt;
   endtask

   task automatic idle_cfg(input logic en, input logic mode, input logic [7:0] bpm,
                           input logic [7:0] exp_bpm, input string tag);
      cfg_valid = 1'b1; cfg_enable = en; cfg_mode = mode; cfg_bpm = bpm;
      @(negedge clk);
      cfg_valid = 1'b0;
      s_en = en; s_mode = mode; s_bpm = exp_bpm;
      chk({tag, "_pend_set"}, cfg_pending, 1'b1);
      predict(1'b0);
      wait_apply(1, tag);
   endtask

   task automatic drive_frame(input int n, input int wr_beat, input int rs_beat,
                              input logic en, input logic mode, input logic [7:0] bpm,
                              input logic [7:0] exp_bpm, input string tag);
      for (int i = 0; i < n; i++) begin
         in_valid = 1'b1; in_ready = 1'b1;
         in_sop = (i == 0) || (i == rs_beat);
         in_eop = (i == n - 1);
         cfg_valid = (i == wr_beat);
         cfg_enable = en; cfg_mode = mode; cfg_bpm = bpm;
         @(negedge clk);
         if (i == wr_beat) begin
            s_en = en; s_mode = mode; s_bpm = exp_bpm;
         end
         if (i < n - 1) begin
            chk({tag, "_mid"}, {filter_enable, filter_mode, BPM_estimate, frame_count},
                {m_en, m_mode, m_bpm, m_fcnt});
            if (wr_beat >= 0 && i >= wr_beat) chk({tag, "_mid_pend"}, cfg_pending, 1'b1);
         end
      end
      in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; cfg_valid = 1'b0;
      predict(1'b1);
   endtask

   initial begin
      reset = 1'b1;
      in_valid = 1'b0; in_ready = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
      cfg_valid = 1'b0; cfg_enable = 1'b0; cfg_mode = 1'b0; cfg_bpm = 8'd0;
      auto_cycle = 1'b0;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      chk("rst_ready", cfg_ready, 1'b1);
      chk_active("rst");
      chk("rst_pend", cfg_pending, 1'b0);
      chk("rst_err",  sop_err,     1'b0);
      reset = 1'b0;
      @(negedge clk);

      idle_cfg(1'b1, 1'b1, 8'd120, 8'd120, "idle_wr");

      drive_frame(16, 4, -1, 1'b1, 1'b0, 8'd250, 8'd200, "mid_wr");
      wait_apply(0, "mid_wr");

      idle_cfg(1'b1, 1'b0, 8'd10,  8'd40,  "clamp10");
      idle_cfg(1'b1, 1'b0, 8'd200, 8'd200, "clamp200");
      idle_cfg(1'b1, 1'b0, 8'd0,   8'd40,  "clamp0");
      idle_cfg(1'b1, 1'b0, 8'd201, 8'd200, "clamp201");
      idle_cfg(1'b1, 1'b0, 8'd40,  8'd40,  "clamp40");

      auto_cycle = 1'b1;
      idle_cfg(1'b1, 1'b1, 8'd100, 8'd100, "auto_shadow");
      for (int k = 1; k <= 6; k++) begin
         drive_frame(4, -1, -1, 1'b0, 1'b0, 8'd0, 8'd0, "auto");
         wait_apply(0, "auto");
         if (k == 3) chk("auto_mode_f3", filter_mode, 1'b1);
      end
      chk("auto_mode_f6", filter_mode, 1'b0);
      chk("auto_fcnt",    frame_count, 16'd7);
      auto_cycle = 1'b0;

      // Non-sop beat in IDLE (carrying eop, which must not end a frame), then a stalled beat.
      in_valid = 1'b1; in_ready = 1'b1; in_sop = 1'b0; in_eop = 1'b1;
      @(negedge clk);
      in_ready = 1'b0; in_sop = 1'b1;
      chk("err_set", sop_err, 1'b1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("err_no_upd", cfg_ready, 1'b1);
      end
      in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
      chk("err_fcnt", frame_count, 16'd7);

      drive_frame(6, -1, 3, 1'b0, 1'b0, 8'd0, 8'd0, "restart");
      wait_apply(0, "restart");
      chk("restart_err", sop_err, 1'b1);
      drive_frame(1, -1, -1, 1'b0, 1'b0, 8'd0, 8'd0, "one_beat");
      wait_apply(0, "one_beat");
      chk("one_beat_fcnt", frame_count, 16'd9);

      // Config request arriving during UPDATE is held off one cycle.
      drive_frame(3, -1, -1, 1'b0, 1'b0, 8'd0, 8'd0, "coll_frame");
      cfg_valid = 1'b1; cfg_enable = 1'b0; cfg_mode = 1'b0; cfg_bpm = 8'd60;
      #1 chk("coll_ready_upd", cfg_ready, 1'b0);
      wait_apply(0, "coll_frame");
      @(negedge clk);
      cfg_valid = 1'b0;
      s_en = 1'b0; s_mode = 1'b0; s_bpm = 8'd60;
      chk("coll_accept", cfg_pending, 1'b1);
      predict(1'b0);
      wait_apply(1, "coll_apply");

      // Asynchronous reset in the middle of a frame with a pending write.
      in_valid = 1'b1; in_ready = 1'b1; in_sop = 1'b1; in_eop = 1'b0;
      @(negedge clk);
      in_sop = 1'b0; cfg_valid = 1'b1; cfg_enable = 1'b1; cfg_mode = 1'b1; cfg_bpm = 8'd150;
      @(negedge clk);
      cfg_valid = 1'b0;
      chk("pre_rst_pend", cfg_pending, 1'b1);
      #2 reset = 1'b1;
      #1;
      model_reset();
      chk_active("async_rst");
      chk("async_rst_pend", cfg_pending, 1'b0);
      chk("async_rst_err",  sop_err,     1'b0);
      chk("async_rst_rdy",  cfg_ready,   1'b1);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      in_eop = 1'b1;
      @(negedge clk);
      in_valid = 1'b0; in_eop = 1'b0;
      chk("post_rst_err", sop_err, 1'b1);
      @(negedge clk);
      chk("post_rst_no_upd", cfg_ready, 1'b1);
      chk("post_rst_fcnt", frame_count, 16'd0);
      drive_frame(2, -1, -1, 1'b0, 1'b0, 8'd0, 8'd0, "post_rst");
      wait_apply(0, "post_rst");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/pixel_filter_ctrl.md
PIXEL_FILTER_CTRL -- requirements
Module: pixel_filter_ctrl

Interface
REQ-001 SHALL have parameter MIN_BPM, default 40: lowest BPM presented to the filter.
REQ-002 SHALL have parameter MAX_BPM, default 200: highest BPM presented to the filter.
REQ-003 SHALL have parameter FRAMES_PER_MODE, default 30: completed frames per mode in auto-cycle.
REQ-004 SHALL have parameter FCNT_W, default 16: frame counter width.
REQ-005 SHALL have local width BPM_W = $clog2(MAX_BPM+1).
REQ-006 SHALL have port clk, input, 1: single clock; all logic on rising edge.
REQ-007 SHALL have port reset, input, 1: asynchronous, active-high.
REQ-008 SHALL have ports in_valid, in_ready, in_sop, in_eop, all input, 1 each: observed pixel stream. Beat = in_valid && in_ready.
REQ-009 SHALL have ports cfg_valid (input, 1) and cfg_ready (output, 1): configuration handshake.
REQ-010 SHALL have ports cfg_enable (input, 1), cfg_mode (input, 1; 0 threshold, 1 additive) and cfg_bpm (input, BPM_W): requested settings.
REQ-011 SHALL have port auto_cycle, input, 1: mode auto-toggle enable, sampled at each update.
REQ-012 SHALL have ports filter_enable (output, 1), filter_mode (output, 1) and BPM_estimate (output, BPM_W): registered active configuration driven to the filter.
REQ-013 SHALL have port frame_count, output, FCNT_W: completed frames.
REQ-014 SHALL have port cfg_pending, output, 1: shadow differs from active, awaiting apply.
REQ-015 SHALL have port sop_err, output, 1: sticky framing error.

Function
REQ-016 SHALL implement states IDLE (between frames), FRAME (inside frame) and UPDATE (one-cycle apply).
REQ-017 SHALL accept config on cfg_valid && cfg_ready and write the shadow registers {enable, mode, clamp(bpm)}; cfg_pending SHALL assert the next cycle.
REQ-018 SHALL clamp BPM as: bpm < MIN_BPM -> MIN_BPM; bpm > MAX_BPM -> MAX_BPM; otherwise unchanged.
REQ-019 SHALL drive cfg_ready = 0 in UPDATE and 1 otherwise, including during reset.
REQ-020 IDLE transitions SHALL be:
  - sop beat without eop -> FRAME.
  - sop beat with eop (one-beat frame) -> UPDATE, counted as a completed frame.
  - no beat and cfg_pending = 1 -> UPDATE, not counted.
  - non-sop beat -> set sop_err, stay in IDLE.
REQ-021 FRAME transitions SHALL be:
  - eop beat -> UPDATE, counted.
  - sop beat without eop -> set sop_err, stay in FRAME (restart, not counted).
  - otherwise hold.
REQ-022 In UPDATE the block SHALL:
  - copy shadow to active outputs, visible on the next edge;
  - clear cfg_pending;
  - increment frame_count if counted, wrapping at 2^FCNT_W to 0;
  - return to IDLE.
REQ-023 Active outputs SHALL change only on the UPDATE exit edge, never mid-frame.
REQ-024 With auto_cycle = 1, a counted UPDATE SHALL increment the mode-frame counter; on reaching FRAMES_PER_MODE-1 it SHALL wrap to 0 and filter_mode SHALL take the inverse of its current value. While auto_cycle = 1 the shadow mode SHALL be ignored. With auto_cycle = 0 the mode-frame counter SHALL hold at 0.
REQ-025 If a config write and UPDATE coincide, the write SHALL be refused (cfg_ready = 0); the requester holds cfg_valid and it is accepted the next cycle.
REQ-026 Latency SHALL be: eop beat at cycle N -> UPDATE at N+1 -> new outputs at N+2.

Reset
REQ-027 Assertion of reset SHALL force asynchronously: state IDLE, filter_enable 0, filter_mode 0, BPM_estimate MIN_BPM, shadow {0, 0, MIN_BPM}, frame_count 0, mode-frame counter 0, cfg_pending 0, sop_err 0.
REQ-028 Reset mid-frame SHALL discard the frame and any pending config; after release the block SHALL wait for the next sop.
REQ-029 sop_err SHALL clear only on reset.

Verification
REQ-030 Idle config write: write {1, 1, 120} while no frame is active -> cfg_pending = 1, then UPDATE; outputs 1/1/120 two cycles after acceptance; frame_count = 0.
REQ-031 Mid-frame write: frame of 16 beats, write {1, 0, 250} at beat 5 -> outputs unchanged until 2 cycles after the eop beat, then BPM_estimate = 200; frame_count = 1.
REQ-032 BPM clamping: cfg_bpm = 10 -> 40; cfg_bpm = 200 -> 200; cfg_bpm = 0 -> 40.
REQ-033 Auto-cycle: auto_cycle = 1, FRAMES_PER_MODE = 3, six 4-beat frames -> filter_mode toggles after frames 3 and 6; frame_count = 6.
REQ-034 Framing errors: a non-sop beat in IDLE -> sop_err = 1 and no state change; a second sop mid-frame -> frame restarts and is not counted.
REQ-035 Collision and reset: cfg_valid held through UPDATE -> accepted one cycle later. Reset asserted mid-frame -> all outputs at reset values immediately, with no clock edge required.
